// File: rtl/spi_test_pkg.sv
// Definitions shared between the SPI master and its receive-side traffic checker.
package spi_test_pkg;

   localparam int SPI_WIDTH        = 8;
   localparam int RELOCK_N_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      CHECK = 2'd2
   } rdState_e;

endpackage

// File: rtl/spi_rx_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/spi_rx_checker.sv
// Drains the SPI RX FIFO and checks received words against an incrementing sequence,
// tracking lock/relock and exposing pass/fail status with error and byte counters.
module spi_rx_checker
   import spi_test_pkg::*;
#(
   parameter int WIDTH        = SPI_WIDTH,
   parameter int ERR_W        = 16,
   parameter int CNT_W        = 32,
   parameter int RELOCK_N     = RELOCK_N_DEFAULT,
   parameter int START_LOCKED = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_empty,
   input  logic [WIDTH-1:0] rx_data,
   output logic             rx_read,
   input  logic             clear,
   output logic             data_good,
   output logic             err_sticky,
   output logic             locked,
   output logic [ERR_W-1:0] err_count,
   output logic [CNT_W-1:0] byte_count
);

   // Wide enough to hold RELOCK_N itself so the drop-lock compare never aliases.
   localparam int MISS_W = (RELOCK_N > 1) ? $clog2(RELOCK_N + 1) : 1;

   rdState_e          state;
   rdState_e          stateNext;
   logic              readNext;
   logic              checkEn;
   logic              isMatch;
   logic              errInc;
   logic              dropLock;
   logic [WIDTH-1:0]  expected;
   logic [MISS_W-1:0] missRun;
   logic [MISS_W-1:0] missInc;

   always_comb begin
      stateNext = state;
      readNext  = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_empty) begin
               readNext  = 1'b1;
               stateNext = READ;
            end
         end
         READ:    stateNext = CHECK;
         CHECK:   stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rx_read <= 1'b0;
      end else begin
         state   <= stateNext;
         rx_read <= readNext;
      end
   end

   assign checkEn  = (state == CHECK);
   assign isMatch  = (rx_data == expected);
   assign errInc   = checkEn && locked && !isMatch;
   assign missInc  = missRun + 1'b1;
   assign dropLock = (RELOCK_N != 0) && (missInc == MISS_W'(RELOCK_N));

   // Unlocked words seed the sequence; locked words advance it whether or not they match.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expected  <= '0;
         locked    <= (START_LOCKED != 0);
         missRun   <= '0;
         data_good <= 1'b1;
      end else if (checkEn) begin
         if (!locked) begin
            expected <= rx_data + 1'b1;
            locked   <= 1'b1;
            missRun  <= '0;
         end else begin
            expected <= expected + 1'b1;
            if (isMatch) begin
               data_good <= 1'b1;
               missRun   <= '0;
            end else begin
               data_good <= 1'b0;
               if (dropLock) begin
                  locked  <= 1'b0;
                  missRun <= '0;
               end else begin
                  missRun <= missInc;
               end
            end
         end
      end
   end

   // clear outranks a coincident CHECK for the counters and the sticky flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
         byte_count <= '0;
      end else if (clear) begin
         err_sticky <= 1'b0;
         byte_count <= '0;
      end else if (checkEn) begin
         byte_count <= byte_count + 1'b1;
         if (errInc) begin
            err_sticky <= 1'b1;
         end
      end
   end

   sat_counter #(
      .W(ERR_W)
   ) u_errCnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(clear),
      .inc  (errInc),
      .count(err_count)
   );

endmodule

// File: tb/tb_spi_rx_checker.sv
// Scoreboard bench: a FIFO model feeds both checker instances (default and 2-bit error
// counter); a monitor compares status after every CHECK against queued expectations.
module tb_spi_rx_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_empty = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        clear = 1'b0;
   logic        monEn = 1'b1;

   logic        rx_read, data_good, err_sticky, locked;
   logic [15:0] err_count;
   logic [31:0] byte_count;
   logic        rx_read_b, data_good_b, err_sticky_b, locked_b;
   logic [1:0]  err_count_b;
   logic [31:0] byte_count_b;

   typedef struct {
      logic       good;
      logic       lck;
      int         err;
      int         errB;
      logic       sticky;
      int         cnt;
   } exp_t;

   logic [7:0] fifoQ[$];
   exp_t       sbQ[$];
   int         total = 0;
   int         bad = 0;

   spi_rx_checker dutA (
      .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty), .rx_data(rx_data), .rx_read(rx_read),
      .clear(clear), .data_good(data_good), .err_sticky(err_sticky), .locked(locked),
      .err_count(err_count), .byte_count(byte_count)
   );

   spi_rx_checker #(.ERR_W(2)) dutB (
      .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty), .rx_data(rx_data), .rx_read(rx_read_b),
      .clear(clear), .data_good(data_good_b), .err_sticky(err_sticky_b), .locked(locked_b),
      .err_count(err_count_b), .byte_count(byte_count_b)
   );

   always #5 clk = ~clk;

   // FIFO model: one-cycle read latency, empty flag refreshed mid-cycle.
   always @(posedge clk) begin
      if (rx_read && fifoQ.size() > 0) rx_data <= fifoQ.pop_front();
   end

   always @(negedge clk) rx_empty = (fifoQ.size() == 0);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, want, $time);
      end
   endtask

   // Monitor: READ seen on a falling edge, status settles after the edge ending CHECK.
   always @(negedge clk) begin
      if (rx_read && monEn) begin
         exp_t e;
         @(posedge clk);
         @(posedge clk);
         #1;
         if (sbQ.size() == 0) begin
            chk("unexpectedRead", 32'd1, 32'd0);
         end else begin
            e = sbQ.pop_front();
            chk("data_good",  32'(data_good),  32'(e.good));
            chk("locked",     32'(locked),     32'(e.lck));
            chk("err_count",  32'(err_count),  32'(e.err));
            chk("errB_count", 32'(err_count_b), 32'(e.errB));
            chk("err_sticky", 32'(err_sticky), 32'(e.sticky));
            chk("byte_count", byte_count,      32'(e.cnt));
         end
      end
   end

   task automatic sendWord(input logic [7:0] d, input logic g, input logic lk, input int e,
                           input int eb, input logic st, input int c);
      exp_t x;
      x.good = g; x.lck = lk; x.err = e; x.errB = eb; x.sticky = st; x.cnt = c;
      fifoQ.push_back(d);
      sbQ.push_back(x);
   endtask

   task automatic drain();
      int n = 0;
      while ((fifoQ.size() != 0 || sbQ.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drainTimeout", 32'(sbQ.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      clear = 1'b0;
      fifoQ.delete();
      @(negedge clk);
      @(negedge clk);
      chk("rst_rx_read",    32'(rx_read),    32'd0);
      chk("rst_data_good",  32'(data_good),  32'd1);
      chk("rst_err_sticky", 32'(err_sticky), 32'd0);
      chk("rst_err_count",  32'(err_count),  32'd0);
      chk("rst_byte_count", byte_count,      32'd0);
      chk("rst_locked",     32'(locked),     32'd0);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      doReset();

      // Basic stream 0x05..0x14: first word locks, the rest match.
      @(negedge clk);
      for (int i = 0; i < 16; i++) sendWord(8'(5 + i), 1, 1, 0, 0, 0, i + 1);
      drain();

      // Wrap through 0xFF -> 0x00; trailing 0x02 confirms expected advanced to 0x02.
      doReset();
      sendWord(8'hFE, 1, 1, 0, 0, 0, 1);
      sendWord(8'hFF, 1, 1, 0, 0, 0, 2);
      sendWord(8'h00, 1, 1, 0, 0, 0, 3);
      sendWord(8'h01, 1, 1, 0, 0, 0, 4);
      sendWord(8'h02, 1, 1, 0, 0, 0, 5);
      drain();

      // Single corruption at word 4.
      doReset();
      sendWord(8'h00, 1, 1, 0, 0, 0, 1);
      sendWord(8'h01, 1, 1, 0, 0, 0, 2);
      sendWord(8'h02, 1, 1, 0, 0, 0, 3);
      sendWord(8'h03, 1, 1, 0, 0, 0, 4);
      sendWord(8'hAA, 0, 1, 1, 1, 1, 5);
      sendWord(8'h05, 1, 1, 1, 1, 1, 6);
      sendWord(8'h06, 1, 1, 1, 1, 1, 7);
      sendWord(8'h07, 1, 1, 1, 1, 1, 8);
      sendWord(8'h08, 1, 1, 1, 1, 1, 9);
      sendWord(8'h09, 1, 1, 1, 1, 1, 10);
      drain();

      // Slip: four misses drop lock, 14 relocks silently, 15 matches.
      doReset();
      sendWord(8'd0,  1, 1, 0, 0, 0, 1);
      sendWord(8'd1,  1, 1, 0, 0, 0, 2);
      sendWord(8'd2,  1, 1, 0, 0, 0, 3);
      sendWord(8'd10, 0, 1, 1, 1, 1, 4);
      sendWord(8'd11, 0, 1, 2, 2, 1, 5);
      sendWord(8'd12, 0, 1, 3, 3, 1, 6);
      sendWord(8'd13, 0, 0, 4, 3, 1, 7);
      sendWord(8'd14, 0, 1, 4, 3, 1, 8);
      sendWord(8'd15, 1, 1, 4, 3, 1, 9);
      drain();

      // Five locked misses (a match breaks the run so lock holds); 2-bit counter pins at 3.
      doReset();
      sendWord(8'h00, 1, 1, 0, 0, 0, 1);
      sendWord(8'h80, 0, 1, 1, 1, 1, 2);
      sendWord(8'h80, 0, 1, 2, 2, 1, 3);
      sendWord(8'h80, 0, 1, 3, 3, 1, 4);
      sendWord(8'h04, 1, 1, 3, 3, 1, 5);
      sendWord(8'h80, 0, 1, 4, 3, 1, 6);
      sendWord(8'h80, 0, 1, 5, 3, 1, 7);
      drain();

      // clear lands on a mismatching CHECK: counters and sticky zero, compare still applies.
      sendWord(8'h80, 0, 1, 0, 0, 0, 0);
      begin
         int n = 0;
         while (!rx_read && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("clearReadTimeout", 32'(n < 50), 32'd1);
         @(negedge clk);
         clear = 1'b1;
         @(negedge clk);
         clear = 1'b0;
      end
      drain();
      sendWord(8'h08, 1, 1, 0, 0, 0, 1);
      drain();

      // Asynchronous reset while a read is in flight.
      monEn = 1'b0;
      fifoQ.push_back(8'h09);
      begin
         int n = 0;
         while (!rx_read && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("rstReadTimeout", 32'(n < 50), 32'd1);
      end
      #1 rst_n = 1'b0;
      #1;
      chk("async_rx_read",    32'(rx_read),    32'd0);
      chk("async_byte_count", byte_count,      32'd0);
      chk("async_locked",     32'(locked),     32'd0);
      chk("async_err_sticky", 32'(err_sticky), 32'd0);
      fifoQ.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("postRst_rx_read", 32'(rx_read), 32'd0);
      end

      chk("sbLeftover", 32'(sbQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_rx_checker.md
# spi_rx_checker

Receive-side traffic checker that sits directly downstream of the SPI master's RX FIFO on the master board. It drains received bytes, compares them against an incrementing reference sequence, tracks lock and relock after slips, and exposes pass/fail status plus saturating error and wrapping byte counters for LEDs and debug. It replaces ad-hoc inline checking in top-level wrappers.

## Interface
Parameters:
- WIDTH, 8, data word width; matches the SPI master's RX data width.
- ERR_W, 16, error counter width; saturates.
- CNT_W, 32, received-word counter width; wraps.
- RELOCK_N, 4, consecutive mismatches that drop lock. A value of 0 disables relock.
- START_LOCKED, 0. When 1, the checker leaves reset locked with expected = 0. When 0, it locks on the first received word.

Ports:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- rx_empty, in, 1, RX FIFO empty flag.
- rx_data, in, WIDTH, RX FIFO read data; one-cycle read latency.
- rx_read, out, 1, RX FIFO read enable; registered single-cycle pulse.
- clear, in, 1, synchronous pulse that clears the counters and the sticky flag.
- data_good, out, 1, result of the most recent locked compare.
- err_sticky, out, 1, set on any locked mismatch; cleared only by reset or clear.
- locked, out, 1, checker is locked to the sequence.
- err_count, out, ERR_W, locked mismatches; saturates at all-ones.
- byte_count, out, CNT_W, words consumed; wraps modulo 2^CNT_W.

## Operation
- Read FSM states: IDLE, READ, CHECK.
  - IDLE: if rx_empty = 0, set rx_read <= 1 and go to READ. Otherwise stay in IDLE.
  - READ: set rx_read <= 0 and go to CHECK. rx_data becomes valid during this cycle.
  - CHECK: sample rx_data, evaluate it per the lock rules below, and return to IDLE.
- Lock FSM is implemented as the `locked` flag plus `expected` (WIDTH bits) and `miss_run` (count of consecutive mismatches).
- Unlocked CHECK:
  - expected <= rx_data + 1 (mod 2^WIDTH), locked <= 1, miss_run <= 0.
  - No error is counted and data_good is unchanged.
- Locked CHECK, match (rx_data == expected):
  - data_good <= 1, miss_run <= 0, expected <= expected + 1.
- Locked CHECK, mismatch:
  - data_good <= 0, err_sticky <= 1, err_count saturating +1, expected <= expected + 1, miss_run +1.
  - If RELOCK_N ≠ 0 and miss_run + 1 == RELOCK_N: locked <= 0 and miss_run <= 0.
- byte_count increments by 1 on every CHECK, locked or unlocked.
- All arithmetic is unsigned. expected wraps from 2^WIDTH-1 to 0, and that wrap is a match, not an error.

## Timing
- Reset values:
  - FSM in IDLE, rx_read = 0, data_good = 1, err_sticky = 0.
  - err_count = 0, byte_count = 0, miss_run = 0, expected = 0, locked = START_LOCKED.
- Throughput is one word per 3 clocks. rx_read is never asserted on two consecutive cycles, and never while rx_empty = 1 was sampled in the same cycle.
- Status latency: data_good, err_*, locked and byte_count update on the edge that ends the CHECK cycle, which is 3 cycles after the IDLE cycle that saw rx_empty = 0.
- clear coincident with a CHECK:
  - clear wins for err_count, byte_count and err_sticky, which all go to 0.
  - The compare still updates data_good, expected, locked and miss_run.
- clear does not touch the FSM, locked or expected.
- err_count held at all-ones stays there on further mismatches. err_sticky still asserts.
- rx_empty rising during READ or CHECK has no effect; the issued read completes.
- Asserting rst_n low mid-transaction forces all reset values immediately (asynchronous). The FIFO read already issued is lost, not replayed.

## Structure
- Shared package spi_test_pkg holds:
  - the read FSM state enum (IDLE/READ/CHECK);
  - the default RELOCK_N;
  - the WIDTH default shared with the SPI master.
- One sub-module: sat_counter, a parameterised saturating up-counter with synchronous clear, used for err_count. byte_count and miss_run are plain registers.
- Reset is asynchronous in every always_ff: posedge clk or negedge rst_n.

## Test plan
- Basic stream: with START_LOCKED = 0, feed 0x05, 0x06 … 0x14 (16 words). Expect locked = 1 after the first CHECK, err_count = 0, byte_count = 16, data_good = 1.
- Wrap: feed 0xFE, 0xFF, 0x00, 0x01. Expect zero errors and expected = 0x02 at the end.
- Single corruption: stream 0x00–0x09 with word 4 = 0xAA. Expect err_count = 1, err_sticky = 1, data_good = 0 only after word 4 and back to 1 after word 5, locked held at 1.
- Slip and relock: stream 0,1,2, then 10,11,12,13,14,15. Expect:
  - 4 errors (10–13), with locked = 0 after the 13;
  - the 14 relocks without counting an error;
  - the 15 matches, giving data_good = 1 and err_count = 4.
- Saturation and clear: with ERR_W = 2, apply 5 mismatches. Expect err_count = 3. Pulse clear in the same cycle as a mismatching CHECK and expect err_count = 0 and err_sticky = 0 on the next cycle.
- Async reset mid-read: drop rst_n during READ. Expect rx_read = 0, byte_count = 0 and locked = START_LOCKED in the same cycle, with no spurious rx_read for 2 cycles after release when rx_empty = 1.
